// File: rtl/sw_pe_gen_if.sv
// Bundle of all non-clock signals of one Smith-Waterman processing element:
// scoring config, resident query, upstream inputs and downstream outputs.
interface sw_pe_gen_if #(
    parameter int CALC_BIT = 10,
    parameter int SYM_BIT  = 2,
    parameter int COL_BIT  = 10
);
    logic                       en;
    logic                       mode_local;
    logic signed [CALC_BIT-1:0] match_i;
    logic signed [CALC_BIT-1:0] mismatch_i;
    logic signed [CALC_BIT-1:0] alpha_i;
    logic signed [CALC_BIT-1:0] beta_i;
    logic                       t_vld_in;
    logic                       t_last_in;
    logic [SYM_BIT-1:0]         t_sym_in;
    logic                       q_vld;
    logic [SYM_BIT-1:0]         q_sym;
    logic signed [CALC_BIT-1:0] v_in;
    logic signed [CALC_BIT-1:0] v_in_a;
    logic signed [CALC_BIT-1:0] f_in_b;
    logic signed [CALC_BIT-1:0] max_in;
    logic [COL_BIT-1:0]         max_col_in;
    logic                       t_vld_out;
    logic                       t_last_out;
    logic [SYM_BIT-1:0]         t_sym_out;
    logic signed [CALC_BIT-1:0] v_out;
    logic signed [CALC_BIT-1:0] v_out_a;
    logic signed [CALC_BIT-1:0] f_out_b;
    logic signed [CALC_BIT-1:0] max_out;
    logic [COL_BIT-1:0]         max_col_out;
    logic [1:0]                 tb_out;
    logic                       update_q_ow;

    modport slave (
        input  en, mode_local, match_i, mismatch_i, alpha_i, beta_i,
               t_vld_in, t_last_in, t_sym_in, q_vld, q_sym,
               v_in, v_in_a, f_in_b, max_in, max_col_in,
        output t_vld_out, t_last_out, t_sym_out, v_out, v_out_a, f_out_b,
               max_out, max_col_out, tb_out, update_q_ow
    );

    modport master (
        output en, mode_local, match_i, mismatch_i, alpha_i, beta_i,
               t_vld_in, t_last_in, t_sym_in, q_vld, q_sym,
               v_in, v_in_a, f_in_b, max_in, max_col_in,
        input  t_vld_out, t_last_out, t_sym_out, v_out, v_out_a, f_out_b,
               max_out, max_col_out, tb_out, update_q_ow
    );
endinterface

// File: rtl/sw_pe_gen.sv
// Smith-Waterman affine-gap processing element: one DP cell per enabled
// valid target symbol, saturating arithmetic, running max and traceback.
module sw_pe_gen #(
    parameter int CALC_BIT = 10,
    parameter int SYM_BIT  = 2,
    parameter int COL_BIT  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    sw_pe_gen_if.slave   bus
);
    typedef logic signed [CALC_BIT-1:0] score_t;
    typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_t;

    localparam score_t S_ZERO = {CALC_BIT{1'b0}};
    localparam score_t S_MAX  = {1'b0, {(CALC_BIT-1){1'b1}}};
    localparam score_t S_MIN  = {1'b1, {(CALC_BIT-1){1'b0}}};

    function automatic score_t sat_add(input score_t a, input score_t b);
        logic [CALC_BIT:0] sum_s;
        sum_s = {a[CALC_BIT-1], a} + {b[CALC_BIT-1], b};
        if (sum_s[CALC_BIT] != sum_s[CALC_BIT-1]) begin
            sat_add = sum_s[CALC_BIT] ? S_MIN : S_MAX;
        end else begin
            sat_add = score_t'(sum_s[CALC_BIT-1:0]);
        end
    endfunction

    state_t               state_r, state_nxt_s;
    logic [COL_BIT-1:0]   col_r;
    score_t               v_diag_r, e_reg_b_r;
    logic                 t_vld_r, t_last_r, upd_r;
    logic [SYM_BIT-1:0]   t_sym_r;
    score_t               v_out_r, v_out_a_r, f_out_b_r, max_r;
    logic [COL_BIT-1:0]   max_col_r;
    logic [1:0]           tb_r;

    logic                 calc_s;
    score_t               f_s, e_s, d_s, sub_s, hm_s, h_s;
    logic [1:0]           tbm_s, tb_s;

    // Cell recurrence: F, E, D, then H with D > F > E tie priority.
    always_comb begin
        calc_s = bus.en & bus.t_vld_in & bus.q_vld;
        f_s    = (bus.f_in_b > bus.v_in_a) ? bus.f_in_b : bus.v_in_a;
        e_s    = (e_reg_b_r > v_out_a_r) ? e_reg_b_r : v_out_a_r;
        sub_s  = (bus.t_sym_in == bus.q_sym) ? bus.match_i : bus.mismatch_i;
        d_s    = sat_add(v_diag_r, sub_s);
        if ((d_s >= f_s) && (d_s >= e_s)) begin
            hm_s  = d_s;
            tbm_s = 2'd1;
        end else if (f_s >= e_s) begin
            hm_s  = f_s;
            tbm_s = 2'd2;
        end else begin
            hm_s  = e_s;
            tbm_s = 2'd3;
        end
        // Local clamp wins only when every candidate is strictly negative.
        if (bus.mode_local && hm_s[CALC_BIT-1]) begin
            h_s  = S_ZERO;
            tb_s = 2'd0;
        end else begin
            h_s  = hm_s;
            tb_s = tbm_s;
        end
    end

    // Next-state logic for the per-target IDLE/CALC sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (calc_s && !bus.t_last_in) state_nxt_s = CALC;
                else                          state_nxt_s = IDLE;
            end
            CALC: begin
                if (bus.en && bus.t_last_in) state_nxt_s = IDLE;
                else                         state_nxt_s = CALC;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else if (bus.en) state_r <= state_nxt_s;
        else state_r <= state_r;
    end

    // Datapath registers; all held while en is low except the one-shot pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r     <= {COL_BIT{1'b0}};
            v_diag_r  <= S_ZERO;
            e_reg_b_r <= S_ZERO;
            t_vld_r   <= 1'b0;
            t_last_r  <= 1'b0;
            t_sym_r   <= {SYM_BIT{1'b0}};
            v_out_r   <= S_ZERO;
            v_out_a_r <= S_ZERO;
            f_out_b_r <= S_ZERO;
            max_r     <= S_ZERO;
            max_col_r <= {COL_BIT{1'b0}};
            tb_r      <= 2'd0;
            upd_r     <= 1'b0;
        end else begin
            upd_r <= bus.en & bus.t_vld_in & bus.t_last_in;
            if (bus.en) begin
                t_vld_r  <= bus.t_vld_in;
                t_last_r <= bus.t_last_in;
                t_sym_r  <= bus.t_sym_in;
                if (calc_s) begin
                    v_out_r   <= h_s;
                    tb_r      <= tb_s;
                    v_out_a_r <= sat_add(h_s, bus.alpha_i);
                    f_out_b_r <= sat_add(f_s, bus.beta_i);
                    if (h_s > bus.max_in) begin
                        max_r     <= h_s;
                        max_col_r <= col_r;
                    end else begin
                        max_r     <= bus.max_in;
                        max_col_r <= bus.max_col_in;
                    end
                    // Last cell wipes the row history so the next target starts clean.
                    if (bus.t_last_in) begin
                        v_diag_r  <= S_ZERO;
                        e_reg_b_r <= S_ZERO;
                        col_r     <= {COL_BIT{1'b0}};
                    end else begin
                        v_diag_r  <= bus.v_in;
                        e_reg_b_r <= sat_add(e_s, bus.beta_i);
                        col_r     <= col_r + {{(COL_BIT-1){1'b0}}, 1'b1};
                    end
                end else begin
                    v_out_r   <= S_ZERO;
                    tb_r      <= 2'd0;
                    v_out_a_r <= bus.alpha_i;
                    f_out_b_r <= bus.beta_i;
                    e_reg_b_r <= bus.beta_i;
                    v_diag_r  <= S_ZERO;
                    max_r     <= bus.max_in;
                    max_col_r <= bus.max_col_in;
                    col_r     <= (state_r == IDLE) ? {COL_BIT{1'b0}} : col_r;
                end
            end
        end
    end

    assign bus.t_vld_out   = t_vld_r;
    assign bus.t_last_out  = t_last_r;
    assign bus.t_sym_out   = t_sym_r;
    assign bus.v_out       = v_out_r;
    assign bus.v_out_a     = v_out_a_r;
    assign bus.f_out_b     = f_out_b_r;
    assign bus.max_out     = max_r;
    assign bus.max_col_out = max_col_r;
    assign bus.tb_out      = tb_r;
    assign bus.update_q_ow = upd_r;
endmodule

// File: tb/tb_sw_pe_gen.sv
// Directed bench for sw_pe_gen: hand-computed cells for match/mismatch,
// saturation, stall, max tracking, last-of-target and asynchronous reset.
module tb_sw_pe_gen;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    sw_pe_gen_if #(.CALC_BIT(10), .SYM_BIT(2), .COL_BIT(10)) bus ();

    sw_pe_gen #(.CALC_BIT(10), .SYM_BIT(2), .COL_BIT(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input bit vld, input bit last, input bit eq,
                         input int vin, input int vina, input int finb);
        bus.t_vld_in  = vld;
        bus.t_last_in = last;
        bus.t_sym_in  = eq ? 2'd1 : 2'd2;
        bus.v_in      = 10'(vin);
        bus.v_in_a    = 10'(vina);
        bus.f_in_b    = 10'(finb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b1;
        bus.en = 1'b0; bus.mode_local = 1'b1;
        bus.match_i = 10'sd2; bus.mismatch_i = -10'sd1;
        bus.alpha_i = -10'sd2; bus.beta_i = -10'sd1;
        bus.q_vld = 1'b1; bus.q_sym = 2'd1;
        bus.max_in = 10'sd5; bus.max_col_in = 10'd7;
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_v_out", bus.v_out, 0);
        check_val("rst_max_out", bus.max_out, 0);
        check_val("rst_upd", bus.update_q_ow, 0);
        tick(); tick();
        rst_n  = 1'b1;
        bus.en = 1'b1;

        // match cell
        tick();
        drive(1'b1, 1'b1, 1'b1, 0, -2, -3); tick();
        check_val("match_v_out", bus.v_out, 2);
        check_val("match_tb", bus.tb_out, 1);
        check_val("match_v_out_a", bus.v_out_a, 0);
        check_val("match_f_out_b", bus.f_out_b, -3);
        check_val("match_max_out", bus.max_out, 5);
        check_val("match_max_col", bus.max_col_out, 7);
        check_val("match_upd", bus.update_q_ow, 1);
        check_val("match_t_vld_out", bus.t_vld_out, 1);

        // mismatch, local then global
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0); tick();
        check_val("idle_upd", bus.update_q_ow, 0);
        check_val("idle_v_out", bus.v_out, 0);
        drive(1'b1, 1'b1, 1'b0, 0, -2, -3); tick();
        check_val("mis_loc_v_out", bus.v_out, 0);
        check_val("mis_loc_tb", bus.tb_out, 0);
        check_val("mis_loc_v_out_a", bus.v_out_a, -2);
        bus.mode_local = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0); tick();
        drive(1'b1, 1'b1, 1'b0, 0, -2, -3); tick();
        check_val("mis_glb_v_out", bus.v_out, -1);
        check_val("mis_glb_tb", bus.tb_out, 1);
        bus.mode_local = 1'b1;

        // positive saturation of D
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0); tick();
        drive(1'b1, 1'b0, 1'b1, 511, 0, 0); tick();
        check_val("sat_c0_v_out", bus.v_out, 2);
        drive(1'b1, 1'b1, 1'b1, 0, 0, 0); tick();
        check_val("sat_pos_v_out", bus.v_out, 511);
        check_val("sat_pos_tb", bus.tb_out, 1);
        check_val("sat_pos_v_out_a", bus.v_out_a, 509);

        // negative saturation of H+alpha and F+beta
        bus.mode_local = 1'b0;
        bus.alpha_i = -10'sd512; bus.beta_i = -10'sd512;
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0); tick();
        bus.alpha_i = -10'sd2; bus.beta_i = -10'sd1; bus.mismatch_i = -10'sd511;
        drive(1'b1, 1'b1, 1'b0, 0, -512, -512); tick();
        check_val("sat_neg_v_out", bus.v_out, -511);
        check_val("sat_neg_v_out_a", bus.v_out_a, -512);
        check_val("sat_neg_f_out_b", bus.f_out_b, -512);
        bus.mismatch_i = -10'sd1;
        bus.mode_local = 1'b1;

        // 4-cell target peaking 6 at column 2, stalled after column 1
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0); tick();
        drive(1'b1, 1'b0, 1'b0, 0, 3, -100); tick();
        check_val("t4_c0_v_out", bus.v_out, 3);
        check_val("t4_c0_tb", bus.tb_out, 2);
        check_val("t4_c0_f_out_b", bus.f_out_b, 2);
        check_val("t4_c0_max_col", bus.max_col_out, 7);
        drive(1'b1, 1'b0, 1'b0, 0, 4, -100); tick();
        check_val("t4_c1_v_out", bus.v_out, 4);
        bus.en = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 100, 100, 100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_v_out", bus.v_out, 4);
            check_val("stall_v_out_a", bus.v_out_a, 2);
            check_val("stall_upd", bus.update_q_ow, 0);
        end
        bus.en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 0, 6, -100); tick();
        check_val("t4_c2_v_out", bus.v_out, 6);
        check_val("t4_c2_max_out", bus.max_out, 6);
        check_val("t4_c2_max_col", bus.max_col_out, 2);
        check_val("t4_c2_upd", bus.update_q_ow, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 1, -100); tick();
        check_val("t4_c3_v_out", bus.v_out, 4);
        check_val("t4_c3_tb", bus.tb_out, 3);
        check_val("t4_c3_max_out", bus.max_out, 5);
        check_val("t4_c3_upd", bus.update_q_ow, 1);
        check_val("t4_c3_t_last_out", bus.t_last_out, 1);
        drive(1'b1, 1'b0, 1'b0, 0, 8, -100); tick();
        check_val("next_upd", bus.update_q_ow, 0);
        check_val("next_max_out", bus.max_out, 8);
        check_val("next_max_col", bus.max_col_out, 0);

        // asynchronous reset mid-target, then restart at column 0
        drive(1'b1, 1'b0, 1'b0, 0, 3, -100);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_v_out", bus.v_out, 0);
        check_val("arst_v_out_a", bus.v_out_a, 0);
        check_val("arst_max_out", bus.max_out, 0);
        check_val("arst_max_col", bus.max_col_out, 0);
        check_val("arst_t_vld_out", bus.t_vld_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 0, 9, -100); tick();
        check_val("post_c0_v_out", bus.v_out, 9);
        check_val("post_c0_max_col", bus.max_col_out, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 10, -100); tick();
        check_val("post_c1_max_out", bus.max_out, 10);
        check_val("post_c1_max_col", bus.max_col_out, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sw_pe_gen.md
SW_PE_GEN -- requirements
Module: sw_pe_gen

Interface
REQ-001 SHALL have parameter CALC_BIT, default 10, signed score width.
REQ-002 SHALL have parameter SYM_BIT, default 2, symbol width.
REQ-003 SHALL have parameter COL_BIT, default 10, column-index width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  advance enable; 0 = stall.
REQ-007 SHALL have port mode_local  input  1  1 = local (clamp at 0), 0 = global.
REQ-008 SHALL have ports match_i, mismatch_i, alpha_i, beta_i  input  CALC_BIT each  signed scores; alpha = gap open, beta = gap extend.
REQ-009 SHALL have ports t_vld_in, t_last_in  input  1 each  target valid and last-of-target.
REQ-010 SHALL have port t_sym_in  input  SYM_BIT  target symbol.
REQ-011 SHALL have ports q_vld, q_sym  input  1 / SYM_BIT  resident query symbol.
REQ-012 SHALL have ports v_in, v_in_a, f_in_b, max_in  input  CALC_BIT each  upstream H, H+alpha, F+beta, running max.
REQ-013 SHALL have port max_col_in  input  COL_BIT  column of max_in.
REQ-014 SHALL have ports t_vld_out, t_last_out, t_sym_out  output  1/1/SYM_BIT  registered target forward.
REQ-015 SHALL have ports v_out, v_out_a, f_out_b, max_out  output  CALC_BIT each  registered downstream values.
REQ-016 SHALL have port max_col_out  output  COL_BIT  column of max_out.
REQ-017 SHALL have port tb_out  output  2  traceback: 0 zero, 1 diag, 2 up (F), 3 left (E).
REQ-018 SHALL have port update_q_ow  output  1  one-cycle pulse on last target cell.

Function
REQ-019 SHALL register all outputs; latency in to out is exactly 1 enabled cycle.
REQ-020 SHALL hold every register when en=0; update_q_ow SHALL be 0 while en=0.
REQ-021 SHALL implement FSM IDLE/CALC; IDLE->CALC on t_vld_in & q_vld & en; CALC->IDLE on enabled cycle with t_last_in=1.
REQ-022 SHALL compute a cell only on an enabled cycle with t_vld_in & q_vld; otherwise v_out=0, tb_out=0, f_out_b=beta_i, e register=beta_i, v_diag=0.
REQ-023 SHALL compute F=max(v_in_a,f_in_b), E=max(v_out_a,e_reg_b), D=v_diag+(t_sym_in==q_sym ? match_i : mismatch_i), all signed.
REQ-024 SHALL set H=max(D,F,E), and in local mode H=max(H,0); global mode SHALL NOT clamp.
REQ-025 SHALL break ties in priority D > F > E; tb_out=0 only when local clamp selects 0 strictly above D,F,E.
REQ-026 SHALL saturate every add (D, H+alpha, F+beta, E+beta) to [-2^(CALC_BIT-1), 2^(CALC_BIT-1)-1].
REQ-027 SHALL latch v_diag<=v_in, e_reg_b<=E+beta, v_out_a<=H+alpha, f_out_b<=F+beta on computed cells.
REQ-028 SHALL keep col counter: 0 in IDLE, incremented per computed cell, wrap at 2^COL_BIT-1 to 0.
REQ-029 SHALL set max_out/max_col_out to (H, col) when H > max_in signed, else (max_in, max_col_in); tie keeps upstream.
REQ-030 SHALL pulse update_q_ow for one cycle on the enabled cycle where t_vld_in & t_last_in.
REQ-031 SHALL clear v_diag, e register and col on CALC->IDLE so the next target starts clean.

Reset
REQ-032 SHALL, while rst_n=0, drive all outputs to 0, state IDLE, col=0, v_diag=0, e_reg_b=0, independent of clk.
REQ-033 SHALL, on reset mid-CALC, abandon the target; first post-reset cell behaves as column 0.

Verification
REQ-034 SHALL test reset: rst_n=0 mid-stream -> all outputs 0 asynchronously, FSM IDLE.
REQ-035 SHALL test match cell, CALC_BIT=10, match=2, mismatch=-1, alpha=-2, beta=-1, v_diag=0, v_in_a=-2, f_in_b=-3, e_reg_b=-1 -> v_out=2, tb_out=1, v_out_a=0, f_out_b=-3.
REQ-036 SHALL test mismatch same inputs: local -> v_out=0, tb_out=0; global -> v_out=-1, tb_out=1.
REQ-037 SHALL test saturation: v_diag=511, match=2 -> v_out=511; v_out=-511, alpha=-2 -> v_out_a=-512.
REQ-038 SHALL test stall: en=0 for 3 cycles mid-target -> outputs and col frozen, update_q_ow=0, resumes identically.
REQ-039 SHALL test last/max: 4-cell target peaking 6 at col 2, max_in=5 -> max_out=6, max_col_out=2, update_q_ow pulses once, next target col starts at 0.
